fifo_rd_scheduler: RTL and testbench



---
 rtl/fifo_rd_scheduler_pkg.sv | 16 +
 rtl/fifo_rd_scheduler_arb.sv | 33 +++
 rtl/fifo_rd_scheduler.sv | 126 ++++++++++++
 tb/tb_fifo_rd_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_scheduler_pkg.sv
// Shared definitions for the FIFO read scheduler: state encoding and default sizing.
package fifo_rd_scheduler_pkg;

  localparam int unsigned DEF_NUM_PORT   = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_BURST_LEN  = 8;
  // Burst counter width; covers BURST_LEN up to 255.
  localparam int unsigned CNT_WIDTH      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/fifo_rd_scheduler_arb.sv
// Round-robin pick: first requesting port at or after rr_ptr, wrapping modulo NUM_PORT.
module rr_arbiter_pick #(
  parameter int unsigned NUM_PORT   = 4,
  parameter int unsigned PORT_WIDTH = 2
) (
  input  logic [NUM_PORT-1:0]   req,
  input  logic [PORT_WIDTH-1:0] rr_ptr,
  output logic [NUM_PORT-1:0]   gnt_oh_c,
  output logic [PORT_WIDTH-1:0] gnt_idx_c,
  output logic                  any_req_c
);

  logic [PORT_WIDTH-1:0] scan_idx;
  logic                  found;

  always_comb begin
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    scan_idx  = '0;
    found     = 1'b0;
    // NUM_PORT is a power of two, so the PORT_WIDTH-bit add wraps naturally.
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      scan_idx = rr_ptr + PORT_WIDTH'(i);
      if (!found && req[scan_idx]) begin
        found              = 1'b1;
        gnt_idx_c          = scan_idx;
        gnt_oh_c[scan_idx] = 1'b1;
      end
    end
    any_req_c = |req;
  end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Read-side scheduler: round-robin bounded bursts over NUM_PORT FIFOs, merged into one tagged stream.
module fifo_rd_scheduler
  import fifo_rd_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORT   = DEF_NUM_PORT,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned PORT_WIDTH = $clog2(NUM_PORT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_en,
  input  logic [NUM_PORT-1:0]            fifo_empty,
  output logic [NUM_PORT-1:0]            fifo_rd_en,
  input  logic [NUM_PORT-1:0]            fifo_valid,
  input  logic [NUM_PORT*DATA_WIDTH-1:0] fifo_dout,
  input  logic                           out_stall,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [PORT_WIDTH-1:0]          out_port,
  output logic                           busy,
  output logic                           burst_done
);

  localparam int unsigned   CW       = CNT_WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  sched_state_e          state;
  logic [PORT_WIDTH-1:0] rr_ptr;
  logic [PORT_WIDTH-1:0] grant;
  logic [NUM_PORT-1:0]   grant_oh;
  logic [PORT_WIDTH-1:0] grant_d;
  logic [CW-1:0]         cnt;

  logic [NUM_PORT-1:0]   pick_oh_c;
  logic [PORT_WIDTH-1:0] pick_idx_c;
  logic                  pick_any_c;
  logic                  grant_empty_c;
  logic                  rd_issue_c;
  logic [DATA_WIDTH-1:0] sel_data_c;

  rr_arbiter_pick #(
    .NUM_PORT   (NUM_PORT),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_pick (
    .req       (~fifo_empty),
    .rr_ptr    (rr_ptr),
    .gnt_oh_c  (pick_oh_c),
    .gnt_idx_c (pick_idx_c),
    .any_req_c (pick_any_c)
  );

  // Read enable follows the live empty/stall inputs so a read is never issued into an empty FIFO.
  assign grant_empty_c = fifo_empty[grant];
  assign rd_issue_c    = (state == BURST) && !grant_empty_c && !out_stall;
  assign fifo_rd_en    = rd_issue_c ? grant_oh : '0;

  // Burst FSM with grant, counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      grant_oh   <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_en && pick_any_c) begin
            grant    <= pick_idx_c;
            grant_oh <= pick_oh_c;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (rd_issue_c) begin
            cnt <= cnt + CW'(1);
          end
          if ((rd_issue_c && (cnt == LAST_CNT)) || grant_empty_c) begin
            burst_done <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          rr_ptr <= grant + PORT_WIDTH'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NUM_PORT; k++) begin
      if (grant_d == PORT_WIDTH'(k)) begin
        sel_data_c = fifo_dout[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // grant_d tracks the port whose read data is returning this cycle; it holds across DRAIN/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_d   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else begin
      grant_d   <= grant;
      out_port  <= grant_d;
      out_valid <= fifo_valid[grant_d];
      out_data  <= fifo_valid[grant_d] ? sel_data_c : '0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Bench for fifo_rd_scheduler: FIFO models, transaction-level scoreboard, directed and random traffic.
module tb_fifo_rd_scheduler;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int BL    = 8;
  localparam int PW    = 2;
  localparam int DEPTH = 1024;
  localparam int OLOG  = 4096;
  localparam int GLOG  = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_en;
  logic               out_stall;
  logic               flush;
  logic [NP-1:0]      fempty = '1;
  logic [NP-1:0]      fvalid = '0;
  logic [NP*DW-1:0]   fdout  = '0;
  logic [NP-1:0]      fifo_rd_en;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [PW-1:0]      out_port;
  logic               busy;
  logic               burst_done;

  fifo_rd_scheduler #(
    .NUM_PORT   (NP),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .PORT_WIDTH (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .fifo_empty (fempty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_valid (fvalid),
    .fifo_dout  (fdout),
    .out_stall  (out_stall),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_port   (out_port),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  // FIFO contents: fmem/fwr owned by the stimulus, frd and flags by the clocked model.
  logic [DW-1:0] fmem [NP][DEPTH];
  int            fwr [NP];
  int            frd [NP];

  always @(posedge clk) begin
    for (int k = 0; k < NP; k++) begin
      if (flush) begin
        frd[k]    <= fwr[k];
        fvalid[k] <= 1'b0;
        fempty[k] <= 1'b1;
      end else if (fifo_rd_en[k] && (frd[k] != fwr[k])) begin
        fdout[k*DW +: DW] <= fmem[k][frd[k] % DEPTH];
        fvalid[k]         <= 1'b1;
        frd[k]            <= frd[k] + 1;
        fempty[k]         <= ((frd[k] + 1) == fwr[k]);
      end else begin
        fvalid[k] <= 1'b0;
        fempty[k] <= (frd[k] == fwr[k]);
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int p, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[p][fwr[p] % DEPTH] = base + DW'(i);
      fwr[p]++;
    end
  endtask

  // Scoreboard state: words delivered per port, burst bookkeeping, logs.
  int orc [NP];
  int cur_port = -1;
  int nxt_rr = 0;
  int breads = 0;
  int exp_len = 0;
  int nbursts = 0;
  int ocnt = 0;
  int lastp = -1;
  int idle_run = 0;
  int gcnt = 0;
  bit had_burst = 1'b0;
  bit rd_h1 = 1'b0;
  bit rd_h2 = 1'b0;
  int olog [OLOG];
  int gap_log [GLOG];

  function automatic bit drained();
    for (int k = 0; k < NP; k++) if (orc[k] != fwr[k]) return 1'b0;
    return !busy && (fifo_rd_en == '0);
  endfunction

  // Reference: every word leaves in FIFO order tagged with its port, two cycles after its read;
  // bursts start at the first non-empty port after the last grant and last min(BURST_LEN, depth).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < NP; k++) orc[k] = frd[k];
        cur_port = -1; nxt_rr = 0; rd_h1 = 1'b0; rd_h2 = 1'b0;
        had_burst = 1'b0; idle_run = 0; gcnt = 0;
      end else begin
        int  p, idx, e, q, avail;
        bit  lat;
        lat = rd_h2;
        if (out_valid || lat) chk(out_valid == lat, "out_latency", longint'(out_valid), longint'(lat));
        rd_h2 = rd_h1;
        rd_h1 = (fifo_rd_en != '0);
        if (out_valid) begin
          p = int'(out_port);
          if (orc[p] < fwr[p]) begin
            chk(out_data == fmem[p][orc[p] % DEPTH], "out_data", longint'(out_data),
                longint'(fmem[p][orc[p] % DEPTH]));
            orc[p]++;
          end else begin
            chk(1'b0, "out_extra_word", longint'(p), -1);
          end
          if (ocnt < OLOG) olog[ocnt] = p;
          ocnt++;
          lastp = p;
        end
        if (fifo_rd_en != '0) begin
          idx = 0;
          for (int k = 0; k < NP; k++) if (fifo_rd_en[k]) idx = k;
          chk($onehot(fifo_rd_en) && !out_stall && !fempty[idx], "rd_legal",
              longint'(fifo_rd_en), longint'(idx));
          if (cur_port < 0) begin
            e = -1;
            for (int i = 0; i < NP; i++) begin
              q = (nxt_rr + i) % NP;
              if (e < 0 && fwr[q] > frd[q]) e = q;
            end
            chk(idx == e, "rr_pick", longint'(idx), longint'(e));
            if (had_burst && gcnt < GLOG) begin
              gap_log[gcnt] = idle_run;
              gcnt++;
            end
            cur_port = idx;
            breads   = 0;
            avail    = fwr[idx] - frd[idx];
            exp_len  = (avail < BL) ? avail : BL;
          end
          breads++;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        if (burst_done) begin
          chk(cur_port >= 0 && breads == exp_len, "burst_len", longint'(breads), longint'(exp_len));
          if (cur_port >= 0) nxt_rr = (cur_port + 1) % NP;
          cur_port  = -1;
          nbursts++;
          had_burst = 1'b1;
        end
      end
    end
  end

  task automatic do_reset(input bit fl);
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush = fl;
    repeat (3) @(posedge clk);
    #1;
    flush     = 1'b0;
    rst_n     = 1'b1;
    cfg_en    = 1'b1;
    out_stall = 1'b0;
  endtask

  task automatic wait_drained(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!drained() && n < budget);
    chk(drained(), nm, longint'(n), longint'(budget));
  endtask

  typedef struct {
    int            port;
    int            nwords;
    logic [DW-1:0] base;
    int            exp_bursts;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int nb0, no0, k, n, bad, ob;

    tbl[0] = '{port: 2, nwords: 3,  base: 16'h00A1, exp_bursts: 1};
    tbl[1] = '{port: 1, nwords: 8,  base: 16'h1100, exp_bursts: 1};
    tbl[2] = '{port: 3, nwords: 12, base: 16'h3300, exp_bursts: 2};
    tbl[3] = '{port: 0, nwords: 1,  base: 16'h0F0F, exp_bursts: 1};
    tbl[4] = '{port: 2, nwords: 17, base: 16'h2200, exp_bursts: 3};

    rst_n = 1'b0; cfg_en = 1'b0; out_stall = 1'b0; flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({fifo_rd_en, out_valid, busy, burst_done} == '0 && out_data == '0 && out_port == '0,
        "reset_outputs", longint'({fifo_rd_en, out_valid, busy, burst_done, out_port}), 0);
    flush = 1'b0; rst_n = 1'b1; cfg_en = 1'b1;

    // Single-port bursts from the vector table.
    for (int i = 0; i < 5; i++) begin
      nb0 = nbursts;
      no0 = ocnt;
      load(tbl[i].port, tbl[i].nwords, tbl[i].base);
      wait_drained(1000, "tbl_drain");
      chk(nbursts - nb0 == tbl[i].exp_bursts, "tbl_bursts", longint'(nbursts - nb0), longint'(tbl[i].exp_bursts));
      chk(ocnt - no0 == tbl[i].nwords, "tbl_words", longint'(ocnt - no0), longint'(tbl[i].nwords));
      chk(lastp == tbl[i].port, "tbl_out_port", longint'(lastp), longint'(tbl[i].port));
    end

    // All ports busy: port order 0,1,2,3 repeating in blocks of BURST_LEN, two idle cycles between bursts.
    do_reset(1'b1);
    no0 = ocnt;
    for (int p = 0; p < NP; p++) load(p, 16, DW'(p * 16'h1000 + 16'h0100));
    wait_drained(2000, "rr_drain");
    bad = 0;
    for (int i = 0; i < 64; i++) if (olog[no0 + i] != (i / BL) % NP) bad++;
    chk(bad == 0, "rr_port_sequence", longint'(bad), 0);
    chk(gcnt == 7, "rr_gap_count", longint'(gcnt), 7);
    bad = 0;
    for (int i = 0; i < 7 && i < gcnt; i++) if (gap_log[i] != 2) bad++;
    chk(bad == 0, "rr_gap_len", longint'(bad), 0);

    // Stall after the third read holds the burst; the two in-flight words still come out.
    do_reset(1'b1);
    load(1, 16, 16'h5100);
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (fifo_rd_en[1]) k++;
    end
    @(posedge clk); #1;
    out_stall = 1'b1;
    bad = 0; ob = 0;
    repeat (5) begin
      @(negedge clk);
      if (fifo_rd_en != '0 || !busy) bad++;
      if (out_valid) ob++;
    end
    chk(bad == 0, "stall_holds", longint'(bad), 0);
    chk(ob == 2, "stall_inflight", longint'(ob), 2);
    @(posedge clk); #1;
    out_stall = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (fifo_rd_en[1]) k++;
    end while (!burst_done && n < 100);
    chk(k == 8, "stall_burst_reads", longint'(k), 8);
    wait_drained(1000, "stall_drain");

    // cfg_en dropped mid-burst: burst completes, then no grants until re-enabled.
    do_reset(1'b1);
    for (int p = 0; p < NP; p++) load(p, 16, DW'(p * 16'h1000 + 16'h0200));
    k = 0; n = 0;
    while (k < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (fifo_rd_en[0]) k++;
    end
    @(posedge clk); #1;
    cfg_en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (fifo_rd_en[0]) k++;
    end while (!burst_done && n < 100);
    chk(k == 8, "cfgoff_burst_reads", longint'(k), 8);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (fifo_rd_en != '0 || busy) bad++;
    end
    chk(bad == 0, "cfgoff_no_grant", longint'(bad), 0);
    @(posedge clk); #1;
    cfg_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fifo_rd_en == '0 && n < 100);
    chk(fifo_rd_en == 4'b0010, "reenable_port1", longint'(fifo_rd_en), 2);

    // Reset during a burst on port 2 after four reads.
    do_reset(1'b1);
    load(2, 16, 16'h7200);
    k = 0; n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (fifo_rd_en[2]) k++;
    end
    load(0, 16, 16'h7000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk({fifo_rd_en, out_valid, busy, burst_done} == '0 && out_data == '0 && out_port == '0,
        "midburst_reset_outputs", longint'({fifo_rd_en, out_valid, busy, burst_done, out_port}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ob = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (out_valid) ob++;
    end while (fifo_rd_en == '0 && n < 100);
    chk(ob == 0, "no_residual_valid", longint'(ob), 0);
    chk(fifo_rd_en == 4'b0001, "post_reset_port0", longint'(fifo_rd_en), 1);
    wait_drained(2000, "reset_drain");

    // Pointer wrap: port 2 then port 3 leave rr_ptr at 0, so port 0 beats port 1.
    do_reset(1'b1);
    load(2, 3, 16'h8200);
    wait_drained(500, "wrap_drain_a");
    load(3, 2, 16'h8300);
    wait_drained(500, "wrap_drain_b");
    load(0, 2, 16'h8000);
    load(1, 2, 16'h8100);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fifo_rd_en == '0 && n < 100);
    chk(fifo_rd_en == 4'b0001, "wrap_port0", longint'(fifo_rd_en), 1);
    wait_drained(500, "wrap_drain_c");

    // Random fill levels with random stall and enable.
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < NP; p++)
        load(p, int'($urandom_range(0, 20)), DW'(p * 16'h1000 + int'($urandom_range(0, 4095))));
      n = 0;
      do begin
        @(posedge clk); #1;
        out_stall = ($urandom_range(0, 3) == 0);
        cfg_en    = ($urandom_range(0, 15) != 0);
        @(negedge clk);
        n++;
      end while (!drained() && n < 3000);
      out_stall = 1'b0;
      cfg_en    = 1'b1;
      chk(drained(), "rand_drain", longint'(n), 3000);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
